// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: turns one cache-line request into a single AXI4 INCR burst on a narrow master port
module cache_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cs_i,
  input  logic                   we_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [LINE_WIDTH-1:0]  wdata_i,
  output logic [LINE_WIDTH-1:0]  rdata_o,
  output logic                   rvalid_o,
  output logic                   err_o,
  output logic [ADDR_WIDTH-1:0]  m_awaddr_o,
  output logic [7:0]             m_awlen_o,
  output logic [2:0]             m_awsize_o,
  output logic [1:0]             m_awburst_o,
  output logic                   m_awvalid_o,
  input  logic                   m_awready_i,
  output logic [BUS_WIDTH-1:0]   m_wdata_o,
  output logic [BUS_WIDTH/8-1:0] m_wstrb_o,
  output logic                   m_wlast_o,
  output logic                   m_wvalid_o,
  input  logic                   m_wready_i,
  input  logic [1:0]             m_bresp_i,
  input  logic                   m_bvalid_i,
  output logic                   m_bready_o,
  output logic [ADDR_WIDTH-1:0]  m_araddr_o,
  output logic [7:0]             m_arlen_o,
  output logic [2:0]             m_arsize_o,
  output logic [1:0]             m_arburst_o,
  output logic                   m_arvalid_o,
  input  logic                   m_arready_i,
  input  logic [BUS_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]             m_rresp_i,
  input  logic                   m_rlast_i,
  input  logic                   m_rvalid_i,
  output logic                   m_rready_o
);
  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEATS-1:0][BUS_WIDTH-1:0] line_q, line_d, rdata_q, rdata_d;
  logic err_q, err_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    line_d = line_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (cs_i) begin
        addr_d = addr_i & ~OFF_MASK;
        line_d = wdata_i;
        err_d = 1'b0;
        cnt_d = '0;
        state_d = we_i ? AW : AR;
      end
      AR: state_d = m_arready_i ? R : AR;
      R: if (m_rvalid_i) begin
        rdata_d[cnt_q] = m_rdata_i;
        err_d = err_q | (m_rresp_i != 2'b00) | (m_rlast_i != (cnt_q == LAST));
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == LAST ? DONE : R;
      end
      AW: state_d = m_awready_i ? W : AW;
      W: if (m_wready_i) begin
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == LAST ? B : W;
      end
      B: if (m_bvalid_i) begin
        err_d = err_q | (m_bresp_i != 2'b00);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      line_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      line_q <= line_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign rdata_o = rdata_q;
  assign rvalid_o = state_q == DONE;
  assign err_o = rvalid_o & err_q;
  assign m_awaddr_o = addr_q;
  assign m_awlen_o = 8'(BEATS - 1);
  assign m_awsize_o = 3'($clog2(BUS_WIDTH / 8));
  assign m_awburst_o = 2'b01;
  assign m_awvalid_o = state_q == AW;
  assign m_wdata_o = line_q[cnt_q];
  assign m_wstrb_o = '1;
  assign m_wvalid_o = state_q == W;
  assign m_wlast_o = m_wvalid_o & (cnt_q == LAST);
  assign m_bready_o = state_q == B;
  assign m_araddr_o = addr_q;
  assign m_arlen_o = 8'(BEATS - 1);
  assign m_arsize_o = 3'($clog2(BUS_WIDTH / 8));
  assign m_arburst_o = 2'b01;
  assign m_arvalid_o = state_q == AR;
  assign m_rready_o = state_q == R;
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: scoreboard bench driving the bridge against a scripted AXI slave
module tb_cache_axi_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b0, we = 1'b0;
  logic [31:0] addr = '0;
  logic [127:0] wdata = '0;
  logic [127:0] rdata_o;
  logic rvalid_o, err_o;
  logic [31:0] m_awaddr_o, m_araddr_o;
  logic [7:0] m_awlen_o, m_arlen_o;
  logic [2:0] m_awsize_o, m_arsize_o;
  logic [1:0] m_awburst_o, m_arburst_o;
  logic m_awvalid_o, m_arvalid_o, m_wlast_o, m_wvalid_o, m_bready_o, m_rready_o;
  logic [31:0] m_wdata_o;
  logic [3:0] m_wstrb_o;
  logic m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0;
  logic m_rlast = 1'b0, m_rvalid = 1'b0;
  logic [1:0] m_bresp = '0, m_rresp = '0;
  logic [31:0] m_rdata = '0;
  typedef struct packed {logic err; logic [127:0] line;} exp_t;
  exp_t sb_q[$];
  int n_chk = 0, n_fail = 0, n_exp = 0, rv_cnt = 0, cyc = 0;
  logic [127:0] last_rd = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cache_axi_bridge dut (
    .clk_i(clk), .rst_ni(rst_n), .cs_i(cs), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o),
    .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o), .m_awsize_o(m_awsize_o),
    .m_awburst_o(m_awburst_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready_o),
    .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o),
    .m_arburst_o(m_arburst_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rlast_i(m_rlast), .m_rvalid_i(m_rvalid),
    .m_rready_o(m_rready_o)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rvalid_o) begin
      exp_t e;
      rv_cnt++;
      if (sb_q.size() == 0) check("unexpected_rvalid", 128'd1, 128'd0);
      else begin
        e = sb_q.pop_front();
        check("rdata", rdata_o, e.line);
        check("err", 128'(err_o), 128'(e.err));
      end
    end
  end
  task automatic do_read(input logic [31:0] a, input logic [127:0] line, input int ar_wait,
                         input int gap, input int last_beat, input logic exp_err, input int kill,
                         input bit hold_cs, input int exp_lat);
    int t0, n;
    if (kill < 0) begin
      sb_q.push_back({exp_err, line});
      n_exp++;
    end
    cs = 1'b1; we = 1'b0; addr = a; wdata = ~line;
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_arvalid_o && n < 20);
    check("ar_seen", 128'(m_arvalid_o), 128'd1);
    check("araddr", 128'(m_araddr_o), 128'(a & ~32'hF));
    check("ar_fields", 128'({m_arlen_o, m_arsize_o, m_arburst_o}), 128'({8'd3, 3'd2, 2'd1}));
    addr = 32'hFFFF_FFF0; we = 1'b1; wdata = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < ar_wait; i++) begin
      m_arready = 1'b0;
      @(negedge clk);
      check("ar_stall", 128'({m_arvalid_o, m_araddr_o}), 128'({1'b1, a & ~32'hF}));
    end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == kill) begin
        rst_n = 1'b0; cs = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        check("rst_outs", 128'({rvalid_o, err_o, m_arvalid_o, m_rready_o, m_awvalid_o,
                                m_wvalid_o, m_wlast_o, m_bready_o}), 128'd0);
        check("rst_rdata", rdata_o, 128'd0);
        rst_n = 1'b1;
        last_rd = '0;
        repeat (3) begin
          @(negedge clk);
          check("no_rvalid_after_kill", 128'(rvalid_o), 128'd0);
        end
        return;
      end
      for (int g = 0; g < gap; g++) begin
        m_rvalid = 1'b0;
        @(negedge clk);
        check("rready_gap", 128'(m_rready_o), 128'd1);
      end
      check("rready", 128'(m_rready_o), 128'd1);
      m_rvalid = 1'b1; m_rdata = line[k*32 +: 32]; m_rlast = (k == last_beat); m_rresp = 2'b00;
      @(negedge clk);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("rd_rvalid_pulse", 128'(rvalid_o), 128'd1);
    if (exp_lat > 0) check("rd_latency", 128'(cyc - t0 + 1), 128'(exp_lat));
    if (!hold_cs) cs = 1'b0;
    last_rd = line;
    @(negedge clk);
    check("rd_rvalid_one_cycle", 128'(rvalid_o), 128'd0);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [127:0] line, input int aw_wait,
                          input int stall_beat, input int stall_n, input logic [1:0] bresp,
                          input int b_wait, input int exp_lat);
    int t0, n;
    sb_q.push_back({(bresp != 2'b00), last_rd});
    n_exp++;
    cs = 1'b1; we = 1'b1; addr = a; wdata = line;
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_awvalid_o && n < 20);
    check("aw_seen", 128'(m_awvalid_o), 128'd1);
    check("awaddr", 128'(m_awaddr_o), 128'(a & ~32'hF));
    check("aw_fields", 128'({m_awlen_o, m_awsize_o, m_awburst_o}), 128'({8'd3, 3'd2, 2'd1}));
    check("w_before_aw", 128'(m_wvalid_o), 128'd0);
    addr = ~a; we = 1'b0; wdata = ~line;
    for (int i = 0; i < aw_wait; i++) begin
      m_awready = 1'b0;
      @(negedge clk);
      check("aw_stall", 128'({m_awvalid_o, m_awaddr_o, m_wvalid_o}), 128'({1'b1, a & ~32'hF, 1'b0}));
    end
    m_awready = 1'b1;
    @(negedge clk);
    m_awready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          m_wready = 1'b0;
          @(negedge clk);
          check("w_stall", 128'({m_wvalid_o, (k == 3), m_wdata_o}), 128'({1'b1, m_wlast_o, line[k*32 +: 32]}));
        end
      end
      check("wbeat", 128'({m_wvalid_o, m_wlast_o, m_wstrb_o, m_wdata_o}),
            128'({1'b1, (k == 3), 4'hF, line[k*32 +: 32]}));
      m_wready = 1'b1;
      @(negedge clk);
    end
    m_wready = 1'b0;
    check("b_no_w", 128'(m_wvalid_o), 128'd0);
    for (int i = 0; i < b_wait; i++) begin
      check("bready_wait", 128'({m_bready_o, rvalid_o}), 128'({1'b1, 1'b0}));
      @(negedge clk);
    end
    check("bready", 128'(m_bready_o), 128'd1);
    m_bvalid = 1'b1; m_bresp = bresp;
    @(negedge clk);
    m_bvalid = 1'b0; m_bresp = 2'b00;
    check("wr_rvalid_pulse", 128'(rvalid_o), 128'd1);
    if (exp_lat > 0) check("wr_latency", 128'(cyc - t0 + 1), 128'(exp_lat));
    cs = 1'b0;
    @(negedge clk);
    check("wr_rvalid_one_cycle", 128'(rvalid_o), 128'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [127:0] l1, l2;
    repeat (2) @(negedge clk);
    check("reset_outs", 128'({rvalid_o, err_o, m_arvalid_o, m_rready_o, m_awvalid_o,
                              m_wvalid_o, m_wlast_o, m_bready_o}), 128'd0);
    check("reset_rdata", rdata_o, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(32'h0000_1234, 128'h00000044_00000033_00000022_00000011, 0, 0, 3, 1'b0, -1, 1'b0, 7);
    do_write(32'h0000_0080, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 2, 3, 2'b00, 1, 0);
    do_write(32'h0000_0ABC, {$urandom, $urandom, $urandom, $urandom}, 0, -1, 0, 2'b00, 0, 8);
    do_read(32'h4000_0008, {$urandom, $urandom, $urandom, $urandom}, 5, 2, 3, 1'b0, -1, 1'b0, 0);
    do_write(32'h0000_0200, {$urandom, $urandom, $urandom, $urandom}, 2, 0, 1, 2'b10, 2, 0);
    do_read(32'h0000_0300, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 3, 1'b0, -1, 1'b0, 7);
    do_read(32'h0000_0410, {$urandom, $urandom, $urandom, $urandom}, 1, 1, 2, 1'b1, -1, 1'b0, 0);
    do_read(32'h0000_0500, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 3, 1'b0, 2, 1'b0, 0);
    l1 = {$urandom, $urandom, $urandom, $urandom};
    do_read(32'h0000_0600, l1, 0, 0, 3, 1'b0, -1, 1'b0, 7);
    l2 = {$urandom, $urandom, $urandom, $urandom};
    do_read(32'h0000_0700, l2, 0, 0, 3, 1'b0, -1, 1'b1, 0);
    do_read(32'h0000_0700, l2, 0, 0, 3, 1'b0, -1, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("sb_empty", 128'(sb_q.size()), 128'd0);
    check("pulse_count", 128'(rv_cnt), 128'(n_exp));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
